// File: rtl/rs232_cmd_pkg.sv
// Shared constants and state encoding for the RS232 command responder.
// Optional checksum support is selected with RS232_CHECKSUM_EN.
package rs232_cmd_pkg;

    localparam logic [7:0] OPC_WRITE = 8'h57;
    localparam logic [7:0] OPC_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        COUNT,
        WR_DATA,
        WR_ACK,
        RD_REQ,
        RD_WAIT,
        RD_SEND,
        CSUM
    } state_t;

    function automatic logic is_timed(input state_t s);
        return (s == ADDR_H) || (s == ADDR_L) || (s == COUNT) || (s == WR_DATA);
    endfunction

endpackage

// File: rtl/rs232_idle_timer.sv
// Restartable inter-byte timeout counter.
// Load restarts it, en lets it run, expire pulses once on the last count.
module rs232_idle_timer #(
    parameter int CLKS = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(CLKS + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(CLKS);
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    // A restart on the same clock always beats expiry.
    assign expire = en && !load && (cnt == W'(1));

endmodule

// File: rtl/rs232_cmd_responder.sv
// Target-side packet decoder for the RS232 debugger (read/write memory).
// Define RS232_CHECKSUM_EN to append an 8-bit data sum to every response.
module rs232_cmd_responder
    import rs232_cmd_pkg::*;
#(
    parameter int CLK_IN_HZ    = 50000000,
    parameter int TIMEOUT_MS   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        ena_tx,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        timeout_err
);

    localparam int TIMEOUT_CLKS = CLK_IN_HZ / 1000 * TIMEOUT_MS;

    state_t      state, state_n;
    logic        opc_w, opc_w_n;
    logic [15:0] addr, addr_n, mem_addr_n;
    logic [8:0]  cnt, cnt_n;
    logic [2:0]  wait_cnt, wait_n;
    logic [7:0]  rd_byte, rd_byte_n;
    logic [7:0]  tx_data_n, mem_wdata_n;
    logic        ena_tx_n, mem_we_n, mem_re_n, timeout_err_n;
    logic        expire, can_tx;
`ifdef RS232_CHECKSUM_EN
    logic [7:0]  sum, sum_n;
    logic        ack_phase, ack_phase_n;
`endif

    rs232_idle_timer #(.CLKS(TIMEOUT_CLKS)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (rx_rdy),
        .en     (is_timed(state)),
        .expire (expire)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            opc_w       <= 1'b0;
            addr        <= '0;
            cnt         <= '0;
            wait_cnt    <= '0;
            rd_byte     <= '0;
            tx_data     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ena_tx      <= 1'b0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            opc_w       <= opc_w_n;
            addr        <= addr_n;
            cnt         <= cnt_n;
            wait_cnt    <= wait_n;
            rd_byte     <= rd_byte_n;
            tx_data     <= tx_data_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            ena_tx      <= ena_tx_n;
            mem_we      <= mem_we_n;
            mem_re      <= mem_re_n;
            timeout_err <= timeout_err_n;
        end
    end

`ifdef RS232_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            ack_phase <= 1'b0;
        end else begin
            sum       <= sum_n;
            ack_phase <= ack_phase_n;
        end
    end
`endif

    // tx_busy lags ena_tx by a clock, so a pulse last clock also blocks.
    assign can_tx = !tx_busy && !ena_tx;

    always_comb begin
        state_n       = state;
        opc_w_n       = opc_w;
        addr_n        = addr;
        cnt_n         = cnt;
        wait_n        = wait_cnt;
        rd_byte_n     = rd_byte;
        tx_data_n     = tx_data;
        mem_addr_n    = mem_addr;
        mem_wdata_n   = mem_wdata;
        ena_tx_n      = 1'b0;
        mem_we_n      = 1'b0;
        mem_re_n      = 1'b0;
        timeout_err_n = 1'b0;
`ifdef RS232_CHECKSUM_EN
        sum_n         = sum;
        ack_phase_n   = ack_phase;
`endif
        unique case (state)
            IDLE: begin
                if (rx_rdy && (rx_data == OPC_WRITE || rx_data == OPC_READ)) begin
                    opc_w_n = (rx_data == OPC_WRITE);
                    state_n = ADDR_H;
                end
            end
            ADDR_H: begin
                if (rx_rdy) begin
                    addr_n  = {rx_data, addr[7:0]};
                    state_n = ADDR_L;
                end
            end
            ADDR_L: begin
                if (rx_rdy) begin
                    addr_n  = {addr[15:8], rx_data};
                    state_n = COUNT;
                end
            end
            COUNT: begin
                if (rx_rdy) begin
                    cnt_n   = {rx_data == 8'h00, rx_data};
                    state_n = opc_w ? WR_DATA : RD_REQ;
`ifdef RS232_CHECKSUM_EN
                    sum_n       = '0;
                    ack_phase_n = 1'b0;
`endif
                end
            end
            WR_DATA: begin
                if (rx_rdy) begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = addr;
                    mem_wdata_n = rx_data;
                    addr_n      = addr + 16'd1;
                    cnt_n       = cnt - 9'd1;
`ifdef RS232_CHECKSUM_EN
                    sum_n       = sum + rx_data;
`endif
                    if (cnt == 9'd1) state_n = WR_ACK;
                end
            end
            WR_ACK: begin
                if (can_tx) begin
                    ena_tx_n = 1'b1;
`ifdef RS232_CHECKSUM_EN
                    tx_data_n   = ack_phase ? sum : RSP_ACK;
                    ack_phase_n = 1'b1;
                    if (ack_phase) state_n = IDLE;
`else
                    tx_data_n = RSP_ACK;
                    state_n   = IDLE;
`endif
                end
            end
            RD_REQ: begin
                wait_n  = '0;
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (wait_cnt == 3'(READ_LATENCY - 1)) begin
                    rd_byte_n = mem_rdata;
                    state_n   = RD_SEND;
                end else begin
                    wait_n = wait_cnt + 3'd1;
                end
            end
            RD_SEND: begin
                if (can_tx) begin
                    ena_tx_n  = 1'b1;
                    tx_data_n = rd_byte;
                    addr_n    = addr + 16'd1;
                    cnt_n     = cnt - 9'd1;
`ifdef RS232_CHECKSUM_EN
                    sum_n     = sum + rd_byte;
                    state_n   = (cnt == 9'd1) ? CSUM : RD_REQ;
`else
                    state_n   = (cnt == 9'd1) ? IDLE : RD_REQ;
`endif
                end
            end
            CSUM: begin
`ifdef RS232_CHECKSUM_EN
                if (can_tx) begin
                    ena_tx_n  = 1'b1;
                    tx_data_n = sum;
                    state_n   = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase

        if (expire) begin
            state_n       = IDLE;
            timeout_err_n = 1'b1;
        end

        // Every read request is issued on entry to RD_REQ.
        mem_re_n = (state_n == RD_REQ);
        if (mem_re_n) mem_addr_n = addr_n;
    end

endmodule

// File: tb/tb_rs232_cmd_responder.sv
// Directed bench for rs232_cmd_responder with memory and UART models.
// Checksum expectations follow RS232_CHECKSUM_EN.
module tb_rs232_cmd_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        ena_tx;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    rs232_cmd_responder #(
        .CLK_IN_HZ    (100000),
        .TIMEOUT_MS   (1),
        .READ_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .ena_tx      (ena_tx),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    logic [7:0] pipe [LAT];
    logic [3:0] ucnt = '0;
    logic       force_busy;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        pipe[0] <= mem_re ? mem[mem_addr] : 8'hEE;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        if (ena_tx) ucnt <= 4'd3;
        else if (ucnt != 0) ucnt <= ucnt - 4'd1;
    end

    assign mem_rdata = pipe[LAT-1];
    assign tx_busy   = force_busy || (ucnt != 0);

    logic [23:0] we_q [$];
    logic [15:0] re_q [$];
    logic [7:0]  tx_q [$];
    int          to_cnt = 0;
    int          dbl    = 0;
    logic        ena_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_we) we_q.push_back({mem_addr, mem_wdata});
        if (mem_re) re_q.push_back(mem_addr);
        if (ena_tx) tx_q.push_back(tx_data);
        if (ena_tx && ena_prev) dbl++;
        ena_prev = ena_tx;
        if (timeout_err) to_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b;
        rx_rdy  = 1'b1;
        @(posedge clk); #1;
        rx_rdy  = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        we_q.delete();
        re_q.delete();
        tx_q.delete();
        to_cnt = 0;
    endtask

    initial begin
        int errs, n;
        logic [7:0] s;

        rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; force_busy = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", {19'b0, ena_tx, mem_we, mem_re, timeout_err, busy,
              tx_data}, 32'd0);
        check("rst_mem", {8'b0, mem_addr, mem_wdata}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // write 2 bytes at 0x1234
        clear_logs();
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h02); send_byte(8'hAA); send_byte(8'h55);
        wait_idle("wr_idle", 200);
        check("wr_n", we_q.size(), 2);
        check("wr_0", {8'b0, we_q[0]}, 32'h1234AA);
        check("wr_1", {8'b0, we_q[1]}, 32'h123555);
        check("wr_mem", {24'b0, mem[16'h1235]}, 32'h55);
        check("wr_ack", {24'b0, tx_q[0]}, 32'h06);
`ifdef RS232_CHECKSUM_EN
        check("wr_txn", tx_q.size(), 2);
        check("wr_sum", {24'b0, tx_q[1]}, 32'hFF);
`else
        check("wr_txn", tx_q.size(), 1);
`endif

        // read with address wrap
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        clear_logs();
        send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
        wait_idle("rd_idle", 200);
        check("rd_ren", re_q.size(), 2);
        check("rd_a0", {16'b0, re_q[0]}, 32'hFFFF);
        check("rd_a1", {16'b0, re_q[1]}, 32'h0000);
        check("rd_d0", {24'b0, tx_q[0]}, 32'h11);
        check("rd_d1", {24'b0, tx_q[1]}, 32'h22);
`ifdef RS232_CHECKSUM_EN
        check("rd_txn", tx_q.size(), 3);
        check("rd_sum", {24'b0, tx_q[2]}, 32'h33);
`else
        check("rd_txn", tx_q.size(), 2);
`endif

        // count 0 means 256 bytes
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        clear_logs();
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_idle("c0_idle", 6000);
        check("c0_ren", re_q.size(), 256);
        errs = 0;
        s = '0;
        for (int i = 0; i < 256; i++) begin
            if (tx_q[i] !== (8'(i) ^ 8'h5A)) errs++;
            s = s + (8'(i) ^ 8'h5A);
        end
        check("c0_data", errs, 0);
`ifdef RS232_CHECKSUM_EN
        check("c0_txn", tx_q.size(), 257);
        check("c0_sum", {24'b0, tx_q[256]}, {24'b0, s});
`else
        check("c0_txn", tx_q.size(), 256);
`endif

        // inter-byte timeout mid-header
        clear_logs();
        send_byte(8'h57); send_byte(8'h12);
        n = 0;
        while (to_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        #1;
        check("to_cnt", to_cnt, 1);
        check("to_busy", {31'b0, busy}, 32'd0);
        check("to_tx", tx_q.size(), 0);
        clear_logs();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h20);
        send_byte(8'h01); send_byte(8'h3C);
        wait_idle("to_idle", 200);
        check("to_wr", {8'b0, we_q[0]}, 32'h00203C);
        check("to_ack", {24'b0, tx_q[0]}, 32'h06);

        // tx backpressure during a read
        mem[16'h0100] = 8'hC3;
        clear_logs();
        force_busy = 1'b1;
        send_byte(8'h52); send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        repeat (5000) @(negedge clk);
        #1;
        check("bp_tx", tx_q.size(), 0);
        check("bp_to", to_cnt, 0);
        check("bp_busy", {31'b0, busy}, 32'd1);
        force_busy = 1'b0;
        wait_idle("bp_idle", 200);
        check("bp_data", {24'b0, tx_q[0]}, 32'hC3);
        check("bp_dbl", dbl, 0);

        // reset in the middle of a write packet
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h03); send_byte(8'hAA);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("mr_out", {19'b0, ena_tx, mem_we, mem_re, timeout_err, busy,
              tx_data}, 32'd0);
        check("mr_mem", {8'b0, mem_addr, mem_wdata}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        send_byte(8'hAA);
        repeat (10) @(posedge clk);
        #1;
        check("mr_busy", {31'b0, busy}, 32'd0);
        check("mr_we", we_q.size(), 0);
        check("mr_tx", tx_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
